// File: rtl/bk_ce_gen.sv
// Clock-enable generator for the BK0011M core: CPU, video, PSG and PS/2 strobes from 96 MHz clk_sys.
// Optional CPU divider stall: define BK_CE_PAUSE_EN to add the pause input.
module bk_ce_gen #(
  parameter int unsigned PSG_DIV  = 56,
  parameter int unsigned PS2_HALF = 3428,
  parameter int unsigned BASE_DIV = 24
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req_turbo,
  input  logic req_bk0010,
  input  logic bus_sync,
`ifdef BK_CE_PAUSE_EN
  input  logic pause,
`endif
  output logic ce_cpu_p,
  output logic ce_cpu_n,
  output logic ce_12mp,
  output logic ce_12mn,
  output logic ce_6mp,
  output logic ce_6mn,
  output logic ce_psg,
  output logic clk_ps2,
  output logic turbo,
  output logic bk0010
);

  localparam int unsigned PSGW = $clog2(PSG_DIV);
  localparam int unsigned PS2W = $clog2(PS2_HALF);

  function automatic int unsigned f_period(input logic t, input logic b);
    int unsigned p;
    p = BASE_DIV + (b ? 8 : 0);
    return t ? (p / 2) : p;
  endfunction

  logic [4:0]      r_cpu_div;
  logic [3:0]      r_div;
  logic [PSGW-1:0] r_psg_div;
  logic [PS2W-1:0] r_ps2_div;
  logic            r_turbo, r_bk0010;
  logic            r_ce_cpu_p, r_ce_cpu_n;
  logic            r_ce_12mp, r_ce_12mn, r_ce_6mp, r_ce_6mn;
  logic            r_ce_psg, r_clk_ps2;

  logic [4:0] w_last, w_half, w_last_nx, w_cpu_div_nx;
  logic       w_boundary, w_switch, w_hold, w_turbo_nx, w_bk0010_nx;

  always_comb begin
    w_last       = 5'(f_period(r_turbo, r_bk0010) - 1);
    w_half       = 5'(f_period(r_turbo, r_bk0010) / 2);
    w_boundary   = (r_cpu_div == w_last);
    w_switch     = w_boundary && !bus_sync;
    w_turbo_nx   = w_switch ? req_turbo  : r_turbo;
    w_bk0010_nx  = w_switch ? req_bk0010 : r_bk0010;
    w_last_nx    = 5'(f_period(w_turbo_nx, w_bk0010_nx) - 1);
`ifdef BK_CE_PAUSE_EN
    w_hold       = w_boundary && pause;
`else
    w_hold       = 1'b0;
`endif
    // A rate switch taken while holding must re-park on the new period's last count.
    if (w_hold)
      w_cpu_div_nx = w_last_nx;
    else if (w_boundary)
      w_cpu_div_nx = '0;
    else
      w_cpu_div_nx = r_cpu_div + 5'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_div  <= '0;
      r_turbo    <= 1'b0;
      r_bk0010   <= 1'b0;
      r_ce_cpu_p <= 1'b0;
      r_ce_cpu_n <= 1'b0;
    end else begin
      r_cpu_div  <= w_cpu_div_nx;
      r_turbo    <= w_turbo_nx;
      r_bk0010   <= w_bk0010_nx;
      r_ce_cpu_p <= (r_cpu_div == 5'd0);
      r_ce_cpu_n <= (r_cpu_div == w_half);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_ce_12mp <= 1'b0;
      r_ce_12mn <= 1'b0;
      r_ce_6mp  <= 1'b0;
      r_ce_6mn  <= 1'b0;
    end else begin
      r_div     <= r_div + 4'd1;
      r_ce_12mp <= (r_div[2:0] == 3'd0);
      r_ce_12mn <= (r_div[2:0] == 3'd4);
      r_ce_6mp  <= (r_div == 4'd0);
      r_ce_6mn  <= (r_div == 4'd8);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_psg_div <= '0;
      r_ce_psg  <= 1'b0;
    end else begin
      r_ce_psg  <= (r_psg_div == '0);
      r_psg_div <= (r_psg_div == PSGW'(PSG_DIV - 1)) ? '0 : r_psg_div + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ps2_div <= '0;
      r_clk_ps2 <= 1'b0;
    end else if (r_ps2_div == PS2W'(PS2_HALF - 1)) begin
      r_ps2_div <= '0;
      r_clk_ps2 <= ~r_clk_ps2;
    end else begin
      r_ps2_div <= r_ps2_div + 1'b1;
    end
  end

  assign ce_cpu_p = r_ce_cpu_p;
  assign ce_cpu_n = r_ce_cpu_n;
  assign ce_12mp  = r_ce_12mp;
  assign ce_12mn  = r_ce_12mn;
  assign ce_6mp   = r_ce_6mp;
  assign ce_6mn   = r_ce_6mn;
  assign ce_psg   = r_ce_psg;
  assign clk_ps2  = r_clk_ps2;
  assign turbo    = r_turbo;
  assign bk0010   = r_bk0010;

endmodule

// File: tb/tb_bk_ce_gen.sv
// Self-checking bench for bk_ce_gen: rate-switch table plus hand-written reset, sync-hold and pause sequences.
module tb_bk_ce_gen;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic req_turbo = 1'b0, req_bk0010 = 1'b0, bus_sync = 1'b0;
`ifdef BK_CE_PAUSE_EN
  logic pause = 1'b0;
`endif
  logic ce_cpu_p, ce_cpu_n, ce_12mp, ce_12mn, ce_6mp, ce_6mn, ce_psg, clk_ps2, turbo, bk0010;

  bk_ce_gen #(.PSG_DIV(56), .PS2_HALF(3428), .BASE_DIV(24)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_turbo(req_turbo), .req_bk0010(req_bk0010),
    .bus_sync(bus_sync),
`ifdef BK_CE_PAUSE_EN
    .pause(pause),
`endif
    .ce_cpu_p(ce_cpu_p), .ce_cpu_n(ce_cpu_n), .ce_12mp(ce_12mp), .ce_12mn(ce_12mn),
    .ce_6mp(ce_6mp), .ce_6mn(ce_6mn), .ce_psg(ce_psg), .clk_ps2(clk_ps2),
    .turbo(turbo), .bk0010(bk0010)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0, passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_p(output int t);
    t = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_sys);
      if (ce_cpu_p) begin t = cyc; break; end
    end
    if (t < 0) chk("ce_cpu_p_timeout", 0, 1);
  endtask

  // Strobe cadence monitor, sampled on the falling edge.
  bit mon_en = 0;
  int lastn = -1, overlap = 0;
  int l12 = -1, l6 = -1, lpsg = -1, lps2 = -1;
  int bad12 = 0, bad6 = 0, badpsg = 0, badps2 = 0, n12 = 0, n6 = 0, npsg = 0, nps2 = 0;
  logic prev_ps2 = 1'b0;
  always @(negedge clk_sys) begin
    if (ce_cpu_n) lastn = cyc;
    if (ce_cpu_p && ce_cpu_n) overlap++;
    if (mon_en) begin
      if (ce_12mp) begin if (l12 >= 0 && cyc - l12 != 8) bad12++; l12 = cyc; n12++; end
      if (ce_12mn && (l12 < 0 || cyc - l12 != 4)) bad12++;
      if (ce_6mp) begin if (l6 >= 0 && cyc - l6 != 16) bad6++; l6 = cyc; n6++; end
      if (ce_6mn && (l6 < 0 || cyc - l6 != 8)) bad6++;
      if (ce_psg) begin if (lpsg >= 0 && cyc - lpsg != 56) badpsg++; lpsg = cyc; npsg++; end
      if (clk_ps2 != prev_ps2) begin
        if (lps2 >= 0 && cyc - lps2 != 3428) badps2++;
        lps2 = cyc; nps2++;
      end
      prev_ps2 = clk_ps2;
    end
  end

  typedef struct {
    bit t;
    bit b;
    int per;
    int half;
  } row_t;

  row_t tbl[5];

  function automatic int allout();
    return int'({ce_cpu_p, ce_cpu_n, ce_12mp, ce_12mn, ce_6mp, ce_6mn, ce_psg, clk_ps2, turbo, bk0010});
  endfunction

  initial begin
    int tprev, t0, t1, cur_p, hits;
    tbl[0] = '{1'b1, 1'b0, 12, 6};
    tbl[1] = '{1'b0, 1'b1, 32, 16};
    tbl[2] = '{1'b1, 1'b1, 16, 8};
    tbl[3] = '{1'b0, 1'b1, 32, 16};
    tbl[4] = '{1'b0, 1'b0, 24, 12};

    // Reset state and first period
    repeat (3) @(negedge clk_sys);
    chk("reset_outputs", allout(), 0);
    reset_n = 1'b1;
    mon_en  = 1;
    @(negedge clk_sys);
    chk("first_p_after_release", int'(ce_cpu_p), 1);
    tprev = cyc;
    wait_p(t1);
    chk("base_period", t1 - tprev, 24);
    chk("base_n_off", lastn - tprev, 12);
    chk("base_turbo", int'(turbo), 0);
    chk("base_bk0010", int'(bk0010), 0);
    tprev = t1;
    cur_p = 24;

    // Rate switch table: request right after a ce_cpu_p
    for (int i = 0; i < 5; i++) begin
      req_turbo  = tbl[i].t;
      req_bk0010 = tbl[i].b;
      wait_p(t0);
      chk("switch_gap_old_p", t0 - tprev, cur_p);
      wait_p(t1);
      chk("new_period", t1 - t0, tbl[i].per);
      chk("new_n_off", lastn - t0, tbl[i].half);
      chk("turbo", int'(turbo), int'(tbl[i].t));
      chk("bk0010", int'(bk0010), int'(tbl[i].b));
      tprev = t1;
      cur_p = tbl[i].per;
    end

    // Request pulse that falls before the boundary is ignored
    req_turbo = 1'b1;
    repeat (5) @(negedge clk_sys);
    req_turbo = 1'b0;
    wait_p(t0);
    chk("glitch_gap", t0 - tprev, 24);
    wait_p(t1);
    chk("glitch_period", t1 - t0, 24);
    chk("glitch_turbo", int'(turbo), 0);
    tprev = t1;

    // bus_sync held over three boundaries
    bus_sync = 1'b1;
    req_turbo = 1'b1;
    req_bk0010 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_p(t0);
      chk("sync_hold_period", t0 - tprev, 24);
      chk("sync_hold_turbo", int'(turbo), 0);
      tprev = t0;
    end
    bus_sync = 1'b0;
    wait_p(t0);
    chk("sync_release_gap", t0 - tprev, 24);
    wait_p(t1);
    chk("sync_new_period", t1 - t0, 16);
    chk("sync_new_n_off", lastn - t0, 8);
    chk("sync_turbo", int'(turbo), 1);
    chk("sync_bk0010", int'(bk0010), 1);
    tprev = t1;

`ifdef BK_CE_PAUSE_EN
    // Pause starting after ce_cpu_n, spanning the boundary
    hits = 0;
    for (int k = 0; k < 50 && !ce_cpu_n; k++) @(negedge clk_sys);
    chk("pause_saw_n", int'(ce_cpu_n), 1);
    pause = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_sys);
      if (ce_cpu_p || ce_cpu_n) hits++;
    end
    chk("pause_no_strobes", hits, 0);
    pause = 1'b0;
    @(negedge clk_sys);
    chk("pause_resume_early", int'(ce_cpu_p), 0);
    @(negedge clk_sys);
    chk("pause_resume_p", int'(ce_cpu_p), 1);
`endif

    // Free run long enough for several PS/2 half-periods, rate flipping midway
    repeat (3600) @(negedge clk_sys);
    req_turbo = 1'b0;
    repeat (3600) @(negedge clk_sys);
    mon_en = 0;
    chk("v12_cadence_bad", bad12, 0);
    chk("v6_cadence_bad", bad6, 0);
    chk("psg_cadence_bad", badpsg, 0);
    chk("ps2_cadence_bad", badps2, 0);
    chk("v12_seen", int'(n12 > 800), 1);
    chk("v6_seen", int'(n6 > 400), 1);
    chk("psg_seen", int'(npsg > 100), 1);
    chk("ps2_edges", int'(nps2 >= 2), 1);
    chk("p_n_overlap", overlap, 0);

    // Reset asserted in the cycle before a ce_cpu_p
    req_bk0010 = 1'b0;
    repeat (3) wait_p(t0);
    wait_p(t1);
    chk("pre_reset_period", t1 - t0, 24);
    repeat (23) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("midreset_outputs", allout(), 0);
    hits = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (allout() != 0) hits++;
    end
    chk("midreset_held_zero", hits, 0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    chk("post_reset_first_p", int'(ce_cpu_p), 1);
    t0 = cyc;
    wait_p(t1);
    chk("post_reset_period", t1 - t0, 24);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
